transmissor_jogada: RTL and testbench

TRANSMISSOR_JOGADA -- requirements
Module: transmissor_jogada

---
 rtl/astro_genius_defs_pkg.sv | 28 ++
 rtl/detector_borda.sv | 19 +
 rtl/transmissor_jogada.sv | 138 +++++++++++++
 tb/tb_transmissor_jogada.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/astro_genius_defs_pkg.sv
// astro_genius_defs_pkg: FSM state encodings, frame constants and data bit order shared with the astro_genius receiver
package astro_genius_defs_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } estado_t;

    localparam int QUADRO_BITS = 9;
    localparam int NUM_DADOS   = 6;

    // Data bit positions inside the pending/shift registers; bit 5 leaves the line first
    localparam int IDX_UP      = 5;
    localparam int IDX_DOWN    = 4;
    localparam int IDX_RIGHT   = 3;
    localparam int IDX_LEFT    = 2;
    localparam int IDX_SPECIAL = 1;
    localparam int IDX_SHOT    = 0;

    // Even parity: the parity bit makes the total count of ones over data+parity even
    function automatic logic paridade_par(input logic [NUM_DADOS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// detector_borda: 6-bit rising-edge detector whose history resets to ones so held buttons do not fire
module detector_borda (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [5:0] i_nivel,
    output logic [5:0] o_borda
);

    logic [5:0] r_anterior;

    // Previous-cycle button levels
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_anterior <= '1;
        else         r_anterior <= i_nivel;
    end

    assign o_borda = i_nivel & ~r_anterior;

endmodule

// File: rtl/transmissor_jogada.sv
// transmissor_jogada: latches button presses and sends them as a 9-bit serial frame to astro_genius
module transmissor_jogada
    import astro_genius_defs_pkg::*;
#(
    parameter int BIT_CICLOS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic       botao_up,
    input  logic       botao_down,
    input  logic       botao_right,
    input  logic       botao_left,
    input  logic       botao_special,
    input  logic       botao_shot,
    output logic       jogada,
    output logic       ocupado,
    output logic       enviado,
    output logic [2:0] db_estado,
    output logic [5:0] db_pendente
);

    localparam int CW = $clog2(BIT_CICLOS);
    localparam logic [CW-1:0] ULTIMO = CW'(BIT_CICLOS - 1);
    localparam logic [2:0] ULTIMO_IDX = 3'(NUM_DADOS - 1);

    estado_t       r_estado, w_estado_prox;
    logic [CW-1:0] r_cnt, w_cnt_prox;
    logic [2:0]    r_idx, w_idx_prox;
    logic [5:0]    r_shift, w_shift_prox;
    logic [5:0]    r_pend, w_pend_prox;
    logic [5:0]    w_botoes, w_borda;
    logic          r_par, w_par_prox;
    logic          r_jogada, r_ocupado, r_enviado;
    logic          w_jogada_prox, w_enviado_prox;
    logic          w_fim_bit, w_carrega;

    // Gather the buttons into the shared data bit order
    always_comb begin
        w_botoes                = '0;
        w_botoes[IDX_UP]        = botao_up;
        w_botoes[IDX_DOWN]      = botao_down;
        w_botoes[IDX_RIGHT]     = botao_right;
        w_botoes[IDX_LEFT]      = botao_left;
        w_botoes[IDX_SPECIAL]   = botao_special;
        w_botoes[IDX_SHOT]      = botao_shot;
    end

    detector_borda u_borda (
        .i_clock (clock),
        .i_reset (reset),
        .i_nivel (w_botoes),
        .o_borda (w_borda)
    );

    assign w_fim_bit = (r_cnt == ULTIMO);

    // Next state, bit timing, bit index and shift register
    always_comb begin
        w_estado_prox = r_estado;
        w_cnt_prox    = w_fim_bit ? '0 : r_cnt + 1'b1;
        w_idx_prox    = r_idx;
        w_shift_prox  = r_shift;
        w_par_prox    = r_par;
        w_carrega     = 1'b0;
        case (r_estado)
            OCIOSO: begin
                w_cnt_prox = '0;
                if (r_pend != '0) begin
                    w_estado_prox = INICIO;
                    w_carrega     = 1'b1;
                    w_shift_prox  = r_pend;
                    w_par_prox    = paridade_par(r_pend);
                end
            end
            INICIO: begin
                if (w_fim_bit) begin
                    w_estado_prox = DADOS;
                    w_idx_prox    = '0;
                end
            end
            DADOS: begin
                if (w_fim_bit) begin
                    if (r_idx == ULTIMO_IDX) begin
                        w_estado_prox = PARIDADE;
                    end else begin
                        w_idx_prox   = r_idx + 3'd1;
                        w_shift_prox = {r_shift[4:0], 1'b0};
                    end
                end
            end
            PARIDADE: w_estado_prox = w_fim_bit ? PARADA : PARIDADE;
            PARADA:   w_estado_prox = w_fim_bit ? OCIOSO : PARADA;
            default:  w_estado_prox = OCIOSO;
        endcase
    end

    // Outputs are computed from the next state so the registered line lines up with the state
    always_comb begin
        w_jogada_prox  = (w_estado_prox == INICIO) ||
                         (w_estado_prox == DADOS && w_shift_prox[5]) ||
                         (w_estado_prox == PARIDADE && w_par_prox);
        w_enviado_prox = (w_estado_prox == PARADA) && (w_cnt_prox == ULTIMO);
        w_pend_prox    = (w_carrega ? 6'b0 : r_pend) | (habilitar ? w_borda : 6'b0);
    end

    // State, counters, data and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_pend    <= '0;
            r_jogada  <= 1'b0;
            r_ocupado <= 1'b0;
            r_enviado <= 1'b0;
        end else begin
            r_estado  <= w_estado_prox;
            r_cnt     <= w_cnt_prox;
            r_idx     <= w_idx_prox;
            r_shift   <= w_shift_prox;
            r_par     <= w_par_prox;
            r_pend    <= w_pend_prox;
            r_jogada  <= w_jogada_prox;
            r_ocupado <= (w_estado_prox != OCIOSO);
            r_enviado <= w_enviado_prox;
        end
    end

    assign jogada      = r_jogada;
    assign ocupado     = r_ocupado;
    assign enviado     = r_enviado;
    assign db_estado   = r_estado;
    assign db_pendente = r_pend;

endmodule

// File: tb/tb_transmissor_jogada.sv
// tb_transmissor_jogada: scoreboard bench; stimulus queues expected frames, a monitor decodes the serial line
module tb_transmissor_jogada;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilitar;
    logic [5:0] b;
    logic       jogada, ocupado, enviado;
    logic [2:0] db_estado;
    logic [5:0] db_pendente;

    int total  = 0;
    int passed = 0;

    logic [8:0] exp_q[$];
    int         k = 0;
    int         env_at, ocup_cnt;
    int         idle_cnt = 0;
    int         last_gap = -1;
    int         frames = 0;
    int         stray_env = 0;
    logic [8:0] bits, e;

    transmissor_jogada #(.BIT_CICLOS(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .habilitar     (habilitar),
        .botao_up      (b[5]),
        .botao_down    (b[4]),
        .botao_right   (b[3]),
        .botao_left    (b[2]),
        .botao_special (b[1]),
        .botao_shot    (b[0]),
        .jogada        (jogada),
        .ocupado       (ocupado),
        .enviado       (enviado),
        .db_estado     (db_estado),
        .db_pendente   (db_pendente)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual === esperado) passed++;
        else $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    endtask

    // Monitor: frames are 36 cycles; bits sampled mid-bit, {start,data[5:0],parity,stop} MSB first
    always @(negedge clock) begin
        if (reset) begin
            k = 0;
        end else begin
            if (k == 0) begin
                if (ocupado) begin
                    k = 1;
                    bits = '0;
                    env_at = 0;
                    ocup_cnt = 0;
                    last_gap = idle_cnt;
                end else begin
                    idle_cnt++;
                    if (enviado) stray_env++;
                end
            end
            if (k > 0) begin
                if ((k - 1) % 4 == 1) bits[8 - (k - 1) / 4] = jogada;
                if (enviado && env_at == 0) env_at = k;
                if (ocupado) ocup_cnt++;
                if (k == 36) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL frame_unexpected: got %b expected no frame", bits);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bits", 32'(bits), 32'(e));
                    end
                    check("enviado_cycle", env_at, 36);
                    check("ocupado_cycles", ocup_cnt, 36);
                    frames++;
                    k = 0;
                    idle_cnt = 0;
                end else begin
                    k++;
                end
            end
        end
    end

    task automatic press(input logic [5:0] m);
        b = m;
        @(negedge clock);
        b = '0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !ocupado) ok = 1;
        end
        check("frames_done", 32'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        habilitar = 1'b1;
        b = '0;
        repeat (2) @(negedge clock);
        check("rst_jogada", 32'(jogada), 0);
        check("rst_ocupado", 32'(ocupado), 0);
        check("rst_enviado", 32'(enviado), 0);
        check("rst_estado", 32'(db_estado), 0);
        check("rst_pendente", 32'(db_pendente), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // single shot press
        exp_q.push_back(9'b1_000001_1_0);
        press(6'b000001);
        check("shot_pendente", 32'(db_pendente), 32'h01);
        check("shot_estado_idle", 32'(db_estado), 0);
        @(negedge clock);
        check("shot_start_ocupado", 32'(ocupado), 1);
        check("shot_start_jogada", 32'(jogada), 1);
        check("shot_pend_cleared", 32'(db_pendente), 0);
        wait_done();

        // up and left together: one frame
        exp_q.push_back(9'b1_100100_0_0);
        press(6'b100100);
        wait_done();

        // down pressed twice mid-frame: frame unchanged, one merged follow-up frame
        exp_q.push_back(9'b1_000001_1_0);
        press(6'b000001);
        repeat (15) @(negedge clock);
        check("mid_estado_dados", 32'(db_estado), 2);
        exp_q.push_back(9'b1_010000_1_0);
        press(6'b010000);
        repeat (2) @(negedge clock);
        press(6'b010000);
        check("mid_pendente", 32'(db_pendente), 32'h10);
        wait_done();
        check("gap_cycles", last_gap, 1);

        // special held across reset release
        reset = 1'b1;
        b = 6'b000010;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("held_pendente", 32'(db_pendente), 0);
        check("held_ocupado", 32'(ocupado), 0);
        b = '0;
        repeat (2) @(negedge clock);
        exp_q.push_back(9'b1_000010_1_0);
        press(6'b000010);
        wait_done();

        // reset at cycle 10 of a down frame (line is high then)
        press(6'b010000);
        repeat (10) @(negedge clock);
        check("abort_pre_jogada", 32'(jogada), 1);
        reset = 1'b1;
        #1;
        check("abort_jogada", 32'(jogada), 0);
        check("abort_enviado", 32'(enviado), 0);
        check("abort_ocupado", 32'(ocupado), 0);
        check("abort_estado", 32'(db_estado), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        exp_q.push_back(9'b1_100000_1_0);
        press(6'b100000);
        wait_done();

        // disabled: all buttons ignored
        habilitar = 1'b0;
        press(6'b111111);
        repeat (3) @(negedge clock);
        check("dis_pendente", 32'(db_pendente), 0);
        check("dis_ocupado", 32'(ocupado), 0);
        check("dis_jogada", 32'(jogada), 0);
        habilitar = 1'b1;
        repeat (40) @(negedge clock);
        check("dis_late_ocupado", 32'(ocupado), 0);

        check("queue_empty", exp_q.size(), 0);
        check("stray_enviado", stray_env, 0);
        check("frame_count", frames, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
